uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, meaning the serial bit rate.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default CLK_FREQ/BAUD (integer division), meaning clk cycles per bit; it SHALL be overridable and must be at least 4.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is reset_n.
REQ-005 Port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port transmitter_data, input, 8 bits: byte to send.
REQ-008 Port startBTNC, input, 1 bit: raw, asynchronous transmit-start button.
REQ-009 Port startBTNU, input, 1 bit: raw, asynchronous receive-clear button.
REQ-010 Port Reciever_data, output, 8 bits: last byte received correctly.

Function
REQ-011 The serial format SHALL be 8N1: a start bit of 0, 8 data bits LSB first, then a stop bit of 1; the line SHALL idle at 1; each bit SHALL last CLKS_PER_BIT cycles.
REQ-012 The TX serial output SHALL connect internally to the RX serial input (loopback); the line is not a port.
REQ-013 Each button SHALL pass through a 2-FF synchronizer followed by a rising-edge detector; no debouncing is performed.
REQ-014 The TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 In IDLE, a startBTNC rising edge SHALL latch transmitter_data and enter START.
REQ-016 The start bit SHALL begin on the line 3 clk cycles after startBTNC rises.
REQ-017 After STOP has lasted CLKS_PER_BIT cycles, TX SHALL return to IDLE.
REQ-018 startBTNC edges outside IDLE SHALL be ignored; a button held high SHALL produce only one frame.
REQ-019 Changes to transmitter_data after the latch SHALL NOT affect the frame in flight.
REQ-020 The RX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-021 RX SHALL leave IDLE on a 1-to-0 transition of the line.
REQ-022 RX SHALL sample the start bit at CLKS_PER_BIT/2 and abort to IDLE if the sample is 1 (glitch).
REQ-023 RX SHALL sample the data and stop bits at their bit centres.
REQ-024 If the stop sample is 1, Reciever_data SHALL be loaded with the assembled byte on the following cycle; if it is 0 (framing error), the byte SHALL be discarded and Reciever_data held.
REQ-025 After the stop-bit sample, RX SHALL return to IDLE.
REQ-026 A startBTNU rising edge SHALL clear Reciever_data to 8'h00.
REQ-027 If a startBTNU edge and a byte load occur in the same cycle, the load SHALL win.
REQ-028 startBTNU SHALL NOT affect TX or the RX FSM.
REQ-029 The bit counter SHALL be 3 bits and the baud counter $clog2(CLKS_PER_BIT) bits; both SHALL reset to 0 at each bit or frame boundary.

Reset
REQ-030 Asserting reset_n low SHALL immediately force both FSMs to IDLE, the line to 1, Reciever_data to 8'h00, and all counters and synchronizers to 0.
REQ-031 A frame in progress when reset asserts SHALL be abandoned and SHALL NOT update Reciever_data.
REQ-032 After reset_n rises, a new button edge SHALL be required before any transmission starts.

Structure
REQ-033 A package uart_pkg SHALL hold the tx_state_t and rx_state_t enums, DATA_BITS=8, and the default CLK_FREQ and BAUD values.
REQ-034 Leaf sub-modules uart_tx and uart_rx SHALL be instantiated by uart_top; the synchronizers and edge detectors SHALL live in uart_top.

Verification (CLKS_PER_BIT=4 unless stated otherwise)
REQ-035 Reset scenario: reset_n=0 -> Reciever_data=8'h00 and line=1; release reset with startBTNC=0 -> no frame is sent.
REQ-036 Loopback scenario: transmitter_data=8'hB5, pulse startBTNC -> line shows 0,1,0,1,0,1,1,0,1,1 (LSB first), and Reciever_data=8'hB5 at 3+40+1 cycles ±2.
REQ-037 Held-button and latch scenario: send 8'hFF with startBTNC held 100 cycles -> exactly one frame; change transmitter_data mid-frame -> Reciever_data=8'hFF.
REQ-038 Clear scenario: after receiving 8'hB5, pulse startBTNU -> Reciever_data=8'h00; then send 8'h3C -> Reciever_data=8'h3C.
REQ-039 Reset mid-frame scenario: assert reset_n during the DATA bits -> Reciever_data=8'h00, line=1; the next button press sends a complete, correct frame.
REQ-040 Default-parameter scenario: with CLKS_PER_BIT=868, send 8'hA5 -> Reciever_data=8'hA5 after about 8680 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the loopback UART.
// Imported by every uart_* file.
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 115_200;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// Serial line bundle between the transmitter and receiver.
// The transmitter is the master and drives the line.
interface uart_if;

  logic line;

  modport master (output line);
  modport slave  (input  line);

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: centre-samples each bit, rejects start
// glitches and pulses valid only on a good stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_if.slave                ser,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  // fall detection already costs one cycle of the bit
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 2);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 prev, valid_n;

  assign data = shreg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      prev    <= 1'b1;
      valid   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      prev    <= ser.line;
      valid   <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    valid_n = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (prev && !ser.line) begin
          cnt_n   = '0;
          state_n = RX_START;
        end
      end
      RX_START: begin
        cnt_n = cnt + CW'(1);
        if (cnt == HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = ser.line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          shreg_n = {ser.line, shreg[DATA_BITS-1:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1))
            state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          valid_n = ser.line;
          state_n = RX_IDLE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: latches a byte on start,
// then shifts start, data (LSB first) and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  uart_if.master               ser
);

  localparam int CW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  tx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 line;

  assign ser.line = line;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    line    = 1'b1;
    unique case (state)
      TX_IDLE: begin
        if (start) begin
          shreg_n = data;
          cnt_n   = '0;
          bit_n   = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        line  = 1'b0;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        line  = shreg[bit_idx];
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n = '0;
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1))
            state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = TX_IDLE;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_top.sv
// Loopback UART: button sync/edge detect, TX wired
// to RX internally, and the received-byte register.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] transmitter_data,
  input  logic                 startBTNC,
  input  logic                 startBTNU,
  output logic [DATA_BITS-1:0] Reciever_data
);

  logic [2:0]           c_sync, u_sync;
  logic                 tx_go, rx_clr, rx_valid;
  logic [DATA_BITS-1:0] rx_byte;

  uart_if link ();

  // two sync stages, third stage is the edge reference
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_sync <= '0;
      u_sync <= '0;
    end else begin
      c_sync <= {c_sync[1:0], startBTNC};
      u_sync <= {u_sync[1:0], startBTNU};
    end
  end

  assign tx_go  = c_sync[1] & ~c_sync[2];
  assign rx_clr = u_sync[1] & ~u_sync[2];

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tx_go),
    .data    (transmitter_data),
    .ser     (link.master)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .ser     (link.slave),
    .data    (rx_byte),
    .valid   (rx_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      Reciever_data <= '0;
    else if (rx_valid)
      Reciever_data <= rx_byte;
    else if (rx_clr)
      Reciever_data <= '0;
  end

endmodule

// File: tb/tb_uart_top.sv
// Directed + random loopback bench for uart_top with
// a frame-level reference model of the 8N1 format.
module tb_uart_top;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] transmitter_data, rdata;
  logic       btn_c, btn_u;
  logic [7:0] td2, rd2;
  logic       bc2, bu2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hold_left = 0;
  int chg_at = -1;
  int lows = 0;
  int hit = -1;
  logic [7:0] watch;
  logic [7:0] exp_rx;

  always #5 clk = ~clk;

  uart_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .transmitter_data (transmitter_data),
    .startBTNC        (btn_c),
    .startBTNU        (btn_u),
    .Reciever_data    (rdata)
  );

  uart_top dut2 (
    .clk              (clk),
    .reset_n          (reset_n),
    .transmitter_data (td2),
    .startBTNC        (bc2),
    .startBTNU        (bu2),
    .Reciever_data    (rd2)
  );

  uart_if mon ();
  assign mon.line = dut.link.line;

  task automatic chk(input string tag,
                     input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d",
             tag, got, want);
    end
  endtask

  task automatic chk_rng(input string tag, input int got,
                         input int lo, input int hi);
    tests++;
    assert (got >= lo && got <= hi) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d..%0d",
             tag, got, lo, hi);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) btn_c = 1'b0;
    end
    if (cyc == chg_at)
      transmitter_data = ~transmitter_data;
    if (mon.line === 1'b0) lows++;
    if (hit < 0 && rdata === watch) hit = cyc;
  endtask

  task automatic send_check(input logic [7:0] b,
                            input int hold, input int chg,
                            input string tag);
    int t0, n;
    logic [9:0] frame, want;
    logic [7:0] prev;
    prev = exp_rx;
    want = {1'b1, b, 1'b0};
    transmitter_data = b;
    btn_c = 1'b1;
    hold_left = hold;
    t0 = cyc;
    chg_at = (chg > 0) ? cyc + chg : -1;
    watch = b;
    hit = -1;
    n = 0;
    while (mon.line !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "/start_lat"}, n, 3);
    for (int k = 0; k < 10; k++) begin
      frame[k] = mon.line;
      repeat (CPB) tick();
    end
    chk({tag, "/frame"}, int'(frame), int'(want));
    lows = 0;
    while (cyc - t0 < 47) tick();
    exp_rx = b;
    chk({tag, "/rx"}, int'(rdata), int'(exp_rx));
    if (prev !== b)
      chk_rng({tag, "/rx_lat"}, hit - t0, 42, 46);
    while (hold_left > 0) tick();
    repeat (20) tick();
    chk({tag, "/one_frame"}, lows, 0);
    chg_at = -1;
  endtask

  task automatic clear_check(input string tag);
    btn_u = 1'b1;
    repeat (2) tick();
    btn_u = 1'b0;
    repeat (4) tick();
    exp_rx = 8'h00;
    chk(tag, int'(rdata), int'(exp_rx));
  endtask

  initial begin
    int t0;
    logic [7:0] b;
    reset_n = 1'b0;
    btn_c = 1'b0;
    btn_u = 1'b0;
    transmitter_data = 8'h00;
    td2 = 8'h00;
    bc2 = 1'b0;
    bu2 = 1'b0;
    watch = 8'h00;
    exp_rx = 8'h00;

    repeat (3) tick();
    chk("rst/rx", int'(rdata), 0);
    chk("rst/line", int'(mon.line), 1);
    chk("rst/rx2", int'(rd2), 0);
    reset_n = 1'b1;
    lows = 0;
    repeat (60) tick();
    chk("rst/no_frame", lows, 0);

    send_check(8'hB5, 1, 0, "b5");
    clear_check("clr1");
    send_check(8'h3C, 2, 0, "3c");
    send_check(8'hFF, 100, 20, "held");

    transmitter_data = 8'h5A;
    btn_c = 1'b1;
    hold_left = 2;
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    exp_rx = 8'h00;
    chk("mid_rst/rx", int'(rdata), int'(exp_rx));
    chk("mid_rst/line", int'(mon.line), 1);
    repeat (2) tick();
    reset_n = 1'b1;
    lows = 0;
    repeat (60) tick();
    chk("mid_rst/idle", lows, 0);
    chk("mid_rst/rx_hold", int'(rdata), 0);
    send_check(8'hC3, 1, 0, "after_rst");

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        clear_check("rnd/clr");
      send_check(b, int'($urandom_range(1, 10)),
                 0, "rnd");
    end

    td2 = 8'hA5;
    bc2 = 1'b1;
    t0 = cyc;
    repeat (3) tick();
    bc2 = 1'b0;
    while (rd2 !== 8'hA5 && cyc - t0 < 12000) tick();
    chk("def/rx", int'(rd2), int'(8'hA5));
    chk_rng("def/lat", cyc - t0, 8000, 9000);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
